// File: rtl/shift_defs.sv
// Shared definitions for the shift sequencer.
//
// Holds the operation-code and FSM-state encodings used by the RTL and by
// the testbench, plus a small helper that classifies op codes.
package shift_defs;

  // Operation codes (3 bits). 3'b111 is reserved and behaves as HOLD.
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // True for the op codes that step the register one bit per clock.
  function automatic logic op_is_shift(input logic [2:0] op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_seq_step.sv
// shift_step: purely combinational single-bit step of the shift register.
//
// Ports:
//   op       - operation code selecting the step kind
//   dout     - current register contents
//   srsi     - serial-in bit entering the MSB on a logical right shift
//   slsi     - serial-in bit entering the LSB on a logical left shift
//   dout_nxt - register contents after one 1-bit step
// Non-stepping op codes (HOLD, LOAD, reserved) pass the value through.
module shift_step
  import shift_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dout,
  input  logic             srsi,
  input  logic             slsi,
  output logic [WIDTH-1:0] dout_nxt
);

  always_comb begin
    // NOTE: the default assignment ahead of the case keeps every path
    // driven, so no latch is inferred for unlisted op codes.
    dout_nxt = dout;
    case (op)
      OP_SRL:  dout_nxt = {srsi, dout[WIDTH-1:1]};
      OP_SLL:  dout_nxt = {dout[WIDTH-2:0], slsi};
      OP_SRA:  dout_nxt = {dout[WIDTH-1], dout[WIDTH-1:1]};
      OP_ROR:  dout_nxt = {dout[0], dout[WIDTH-1:1]};
      OP_ROL:  dout_nxt = {dout[WIDTH-2:0], dout[WIDTH-1]};
      default: dout_nxt = dout;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift/rotate sequencer.
//
// A start in IDLE latches op and amt. LOAD and no-op requests (HOLD,
// reserved, amt==0) complete straight to DONE; shift requests spend amt
// cycles in SHIFT doing one 1-bit step per clock, then one cycle in DONE.
//
// Ports:
//   clk   - rising-edge clock
//   clr   - asynchronous active-low reset
//   start - request, sampled only in IDLE
//   op    - operation code, latched at start
//   amt   - shift count, latched at start (clamped to WIDTH-1)
//   din   - parallel load data
//   srsi  - serial-in for logical right shift (enters MSB)
//   slsi  - serial-in for logical left shift (enters LSB)
//   dout  - register contents
//   busy  - high whenever the FSM is not in IDLE
//   done  - one-cycle completion pulse
module shift_seq
  import shift_defs::*;
#(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] din,
  input  logic             srsi,
  input  logic             slsi,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  // Compared one bit wider so the clamp is not a constant comparison when
  // WIDTH is a power of two.
  localparam logic [AW:0] AMT_MAX = (AW+1)'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic [WIDTH-1:0] step_val;
  logic [AW:0]      amt_ext;
  logic [AW-1:0]    amt_eff;

  // Counts beyond WIDTH-1 only exist for non-power-of-two WIDTH.
  assign amt_ext = {1'b0, amt};
  assign amt_eff = (amt_ext > AMT_MAX) ? AMT_MAX[AW-1:0] : amt;

  // The step always uses the latched op, so op changes while busy are inert.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .dout     (dout_q),
    .srsi     (srsi),
    .slsi     (slsi),
    .dout_nxt (step_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = op;
          if (op == OP_LOAD) begin
            dout_d  = din;
            state_d = ST_DONE;
          end else if (!op_is_shift(op) || (amt_eff == '0)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = amt_eff;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        dout_d = step_val;
        cnt_d  = cnt_q - AW'(1);
        // Last step happens on the edge that sees cnt==1.
        if (cnt_q == AW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Completion always lasts exactly one cycle; start is ignored here.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq at WIDTH=8, 16 and 5.
module tb_shift_seq;
  import shift_defs::*;

  typedef struct {
    logic [15:0] val;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8, srsi8, slsi8, busy8, done8;
  logic [2:0] op8, amt8;
  logic [7:0] din8, dout8;

  // WIDTH=16 instance
  logic        start16, srsi16, slsi16, busy16, done16;
  logic [2:0]  op16;
  logic [3:0]  amt16;
  logic [15:0] din16, dout16;

  // WIDTH=5 instance (non-power-of-two, exercises amt clamping)
  logic       start5, srsi5, slsi5, busy5, done5;
  logic [2:0] op5, amt5;
  logic [4:0] din5, dout5;

  shift_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .clr(clr), .start(start8), .op(op8), .amt(amt8), .din(din8),
    .srsi(srsi8), .slsi(slsi8), .dout(dout8), .busy(busy8), .done(done8)
  );

  shift_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .clr(clr), .start(start16), .op(op16), .amt(amt16), .din(din16),
    .srsi(srsi16), .slsi(slsi16), .dout(dout16), .busy(busy16), .done(done16)
  );

  shift_seq #(.WIDTH(5)) u_dut5 (
    .clk(clk), .clr(clr), .start(start5), .op(op5), .amt(amt5), .din(din5),
    .srsi(srsi5), .slsi(slsi5), .dout(dout5), .busy(busy5), .done(done5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 transaction, started at a negedge. Latency is the number of
  // negedges from the start until done is seen. With disturb set, a LOAD
  // request is presented mid-shift and again during the DONE cycle.
  task automatic run8(input string tag, input logic [2:0] o, input logic [2:0] a,
                      input logic [7:0] d, input logic [7:0] ev, input int el,
                      input bit disturb);
    int   lat;
    exp_t e;
    sb_q.push_back('{val: 16'(ev), lat: el});
    start8 = 1'b1; op8 = o; amt8 = a; din8 = d;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      if (disturb && lat == 2) begin
        start8 = 1'b1; op8 = OP_LOAD; din8 = 8'h00; amt8 = 3'd1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    if (disturb) begin
      start8 = 1'b1; op8 = OP_LOAD; din8 = 8'h00;
    end
    e = sb_q.pop_front();
    check({tag, " result"}, 32'(dout8), 32'(e.val));
    check({tag, " latency"}, 32'(lat), 32'(e.lat));
    @(negedge clk);
    start8 = 1'b0;
    check({tag, " busy/done after"}, 32'({busy8, done8}), 32'b0);
    check({tag, " dout holds"}, 32'(dout8), 32'(e.val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   n_done;
    exp_t e;

    clr = 1'b0;
    start8 = 0; op8 = OP_HOLD; amt8 = 0; din8 = 0; srsi8 = 0; slsi8 = 0;
    start16 = 0; op16 = OP_HOLD; amt16 = 0; din16 = 0; srsi16 = 0; slsi16 = 0;
    start5 = 0; op5 = OP_HOLD; amt5 = 0; din5 = 0; srsi5 = 0; slsi5 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset dout8", 32'(dout8), 32'h0);
    check("reset busy8/done8", 32'({busy8, done8}), 32'b0);
    check("reset dout16", 32'(dout16), 32'h0);
    check("reset busy5/done5", 32'({busy5, done5}), 32'b0);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    check("idle hold dout8", 32'(dout8), 32'h0);

    // LOAD A5
    run8("load_a5", OP_LOAD, 3'd0, 8'hA5, 8'hA5, 1, 1'b0);

    // SRL amt=3 srsi=1, step by step: D2, E9, F4 with done alongside F4
    srsi8 = 1'b1;
    sb_q.push_back('{val: 16'h00D2, lat: 0});
    sb_q.push_back('{val: 16'h00E9, lat: 0});
    sb_q.push_back('{val: 16'h00F4, lat: 1});
    start8 = 1'b1; op8 = OP_SRL; amt8 = 3'd3;
    @(negedge clk);
    start8 = 1'b0;
    check("srl3 first cycle dout", 32'(dout8), 32'hA5);
    check("srl3 first cycle busy", 32'(busy8), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("srl3 step%0d dout", i), 32'(dout8), 32'(e.val));
      check($sformatf("srl3 step%0d done", i), 32'(done8), 32'(e.lat));
    end
    @(negedge clk);
    check("srl3 after busy/done", 32'({busy8, done8}), 32'b0);
    srsi8 = 1'b0;

    run8("load_90", OP_LOAD, 3'd0, 8'h90, 8'h90, 1, 1'b0);
    run8("sra2", OP_SRA, 3'd2, 8'h00, 8'hE4, 3, 1'b0);
    run8("load_81a", OP_LOAD, 3'd0, 8'h81, 8'h81, 1, 1'b0);
    run8("rol3", OP_ROL, 3'd3, 8'h00, 8'h0C, 4, 1'b0);
    run8("load_81b", OP_LOAD, 3'd0, 8'h81, 8'h81, 1, 1'b0);
    run8("ror1", OP_ROR, 3'd1, 8'h00, 8'hC0, 2, 1'b0);
    run8("sll0", OP_SLL, 3'd0, 8'h00, 8'hC0, 1, 1'b0);
    run8("hold3", OP_HOLD, 3'd3, 8'h00, 8'hC0, 1, 1'b0);
    run8("rsvd2", OP_RSVD, 3'd2, 8'h00, 8'hC0, 1, 1'b0);
    slsi8 = 1'b1;
    run8("sll2_slsi1", OP_SLL, 3'd2, 8'h00, 8'h03, 3, 1'b0);
    slsi8 = 1'b0;
    // Mid-flight LOAD request and a start held through DONE are both ignored
    run8("ror4_disturbed", OP_ROR, 3'd4, 8'h00, 8'h30, 5, 1'b1);
    run8("load_80", OP_LOAD, 3'd0, 8'h80, 8'h80, 1, 1'b0);
    run8("sra7", OP_SRA, 3'd7, 8'h00, 8'hFF, 8, 1'b0);

    // Asynchronous reset in the middle of SRL amt=5
    start8 = 1'b1; op8 = OP_SRL; amt8 = 3'd5;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    check("srl5 busy before clr", 32'(busy8), 32'h1);
    #2 clr = 1'b0;
    #1;
    check("async clr dout8", 32'(dout8), 32'h0);
    check("async clr busy8/done8", 32'({busy8, done8}), 32'b0);
    @(negedge clk);
    clr = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8 || busy8) n_done++;
    end
    check("no done/busy after abort", 32'(n_done), 32'h0);
    run8("load_3c", OP_LOAD, 3'd0, 8'h3C, 8'h3C, 1, 1'b0);

    // WIDTH=5: ROL with amt=7 clamps to 4 steps
    start5 = 1'b1; op5 = OP_LOAD; din5 = 5'b00001;
    @(negedge clk);
    start5 = 1'b0;
    check("w5 load", 32'(dout5), 32'h01);
    @(negedge clk);
    sb_q.push_back('{val: 16'h0010, lat: 5});
    start5 = 1'b1; op5 = OP_ROL; amt5 = 3'd7;
    @(negedge clk);
    start5 = 1'b0;
    lat = 1;
    while (!done5 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    check("w5 rol clamp result", 32'(dout5), 32'(e.val));
    check("w5 rol clamp latency", 32'(lat), 32'(e.lat));
    @(negedge clk);

    // WIDTH=16: SLL of 0x0001 by 15 with slsi=0
    start16 = 1'b1; op16 = OP_LOAD; din16 = 16'h0001;
    @(negedge clk);
    start16 = 1'b0;
    check("w16 load", 32'(dout16), 32'h0001);
    @(negedge clk);
    sb_q.push_back('{val: 16'h8000, lat: 16});
    start16 = 1'b1; op16 = OP_SLL; amt16 = 4'd15;
    @(negedge clk);
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    check("w16 sll15 result", 32'(dout16), 32'(e.val));
    check("w16 sll15 latency", 32'(lat), 32'(e.lat));
    @(negedge clk);
    check("w16 after busy/done", 32'({busy16, done16}), 32'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data register width (>=2).
REQ-002 SHALL have derived localparam: AW, $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: clr  input  1  reset; one clock; reset asynchronous, active-low.
REQ-005 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port: op  input  3  operation code, latched at start.
REQ-007 SHALL have port: amt  input  AW  shift count 0..WIDTH-1, latched at start.
REQ-008 SHALL have port: din  input  WIDTH  parallel load data.
REQ-009 SHALL have port: srsi  input  1  serial-in for right logical shift (enters MSB).
REQ-010 SHALL have port: slsi  input  1  serial-in for left logical shift (enters LSB).
REQ-011 SHALL have port: dout  output  WIDTH  register contents.
REQ-012 SHALL have port: busy  output  1  high whenever state != IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL encode op: 000 HOLD, 001 SRL, 010 SLL, 011 LOAD, 100 SRA, 101 ROR, 110 ROL, 111 reserved = HOLD.
REQ-015 SHALL implement states IDLE, SHIFT, DONE; busy = (SHIFT or DONE); done = (state == DONE).
REQ-016 IDLE, start=1 at edge k: LOAD -> dout<=din, state<=DONE; HOLD/reserved or amt==0 -> dout unchanged, state<=DONE; else cnt<=amt, state<=SHIFT.
REQ-017 SHIFT: each edge performs exactly one 1-bit step of latched op and decrements cnt; edge with cnt==1 -> state<=DONE.
REQ-018 Latency: shift of amt=N>0 occupies edges k+1..k+N; done high during cycle after edge k+N; IDLE at edge k+N+1.
REQ-019 DONE SHALL always return to IDLE on next edge; start during DONE ignored.
REQ-020 SRL step: {srsi, dout[WIDTH-1:1]}; SLL step: {dout[WIDTH-2:0], slsi}; srsi/slsi sampled live each step.
REQ-021 SRA step: {dout[WIDTH-1], dout[WIDTH-1:1]}; ROR: {dout[0], dout[WIDTH-1:1]}; ROL: {dout[WIDTH-2:0], dout[WIDTH-1]}.
REQ-022 start, op, amt, din changes while busy SHALL have no effect on the operation in flight.
REQ-023 In IDLE without start, dout SHALL hold.
REQ-024 amt values >= WIDTH (non-power-of-2 WIDTH) SHALL be clamped to WIDTH-1.

Reset
REQ-025 clr=0 SHALL immediately, independent of clk, force dout=0, state=IDLE, cnt=0, busy=0, done=0.
REQ-026 Reset mid-SHIFT SHALL abort the operation with no done pulse; first start after clr release SHALL behave per REQ-016.

Structure
REQ-027 Op-code and state encodings SHALL live as constants in shared package/header shift_defs, reused by bench.
REQ-028 One combinational sub-module shift_step (inputs: op, dout, srsi, slsi; output: next value) SHALL compute the 1-bit step; FSM/counter stay in shift_seq.

Verification (WIDTH=8 unless stated)
REQ-029 LOAD din=8'hA5 -> dout=8'hA5 after edge k, done high next cycle only, busy low after.
REQ-030 dout=8'hA5, SRL amt=3 srsi=1 -> dout D2, E9, F4 on successive edges; done one cycle after F4.
REQ-031 dout=8'h90, SRA amt=2 -> 8'hE4; dout=8'h81, ROL amt=3 -> 8'h0C; dout=8'h81, ROR amt=1 -> 8'hC0.
REQ-032 SLL amt=0 -> done next cycle, dout unchanged; second start pulse during SHIFT -> ignored, cycle count unchanged.
REQ-033 clr low during SHIFT of SRL amt=5 -> dout=8'h00, busy=0 immediately, no done; next LOAD 8'h3C -> 8'h3C.
REQ-034 WIDTH=16: dout=16'h0001, SLL amt=15 slsi=0 -> dout=16'h8000 after 15 shift edges, then done.
